// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single external memory port between fetch and data requests.
// One transaction at a time, data has priority, stale fetches are dropped, hung memory times out.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_Req,
  input  logic [31:0] IF_Address,
  input  logic        IF_Flush,
  output logic        IF_Ack,
  output logic [31:0] IF_RData,
  input  logic        DM_Req,
  input  logic        DM_R_W,
  input  logic [2:0]  DM_Size,
  input  logic [31:0] DM_Address,
  input  logic [31:0] DM_WData,
  output logic        DM_Ack,
  output logic [31:0] DM_RData,
  output logic        MEM_V,
  output logic        MEM_Cst_R_W,
  output logic [2:0]  MEM_Cst_Size,
  output logic [31:0] MEM_Address_o,
  output logic [31:0] MEM_RES_o,
  input  logic [31:0] MEM_Data_Out_i,
  input  logic        MEM_Ready_i,
  output logic        ERR
);

  localparam int DATA_W = 32;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF, RESP} state_t;
  typedef enum logic {OWN_DM, OWN_IF} own_t;

  state_t             state;
  own_t               own;
  logic               drop;
  logic [15:0]        cnt;
  logic [DATA_W-1:0]  rdata;
  logic               dm_ack_r;
  logic               if_ack_r;
  logic               busy;
  logic               flush_hit;
  logic               to_hit;

  assign busy      = (state == BUSY_DM) || (state == BUSY_IF);
  assign flush_hit = (state == BUSY_IF) && IF_Flush;
  assign to_hit    = busy && !MEM_Ready_i && (cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      own           <= OWN_DM;
      drop          <= 1'b0;
      cnt           <= '0;
      rdata         <= '0;
      dm_ack_r      <= 1'b0;
      if_ack_r      <= 1'b0;
      MEM_V         <= 1'b0;
      MEM_Cst_R_W   <= 1'b0;
      MEM_Cst_Size  <= '0;
      MEM_Address_o <= '0;
      MEM_RES_o     <= '0;
      ERR           <= 1'b0;
    end else begin
      dm_ack_r <= 1'b0;
      if_ack_r <= 1'b0;
      case (state)
        IDLE: begin
          if (DM_Req) begin
            MEM_V         <= 1'b1;
            MEM_Cst_R_W   <= DM_R_W;
            MEM_Cst_Size  <= DM_Size;
            MEM_Address_o <= DM_Address;
            MEM_RES_o     <= DM_WData;
            own           <= OWN_DM;
            cnt           <= '0;
            state         <= BUSY_DM;
          end else if (IF_Req && !IF_Flush) begin
            MEM_V         <= 1'b1;
            MEM_Cst_R_W   <= 1'b0;
            MEM_Cst_Size  <= 3'b010;
            MEM_Address_o <= IF_Address;
            own           <= OWN_IF;
            drop          <= 1'b0;
            cnt           <= '0;
            state         <= BUSY_IF;
          end
        end
        BUSY_DM, BUSY_IF: begin
          drop <= drop | flush_hit;
          if (MEM_Ready_i || to_hit) begin
            // A timeout completes like a normal transfer but returns zero data.
            rdata    <= MEM_Ready_i ? MEM_Data_Out_i : '0;
            ERR      <= ERR | to_hit;
            MEM_V    <= 1'b0;
            dm_ack_r <= (own == OWN_DM);
            if_ack_r <= (own == OWN_IF) && !drop && !flush_hit;
            state    <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A redirect arriving during the acknowledge cycle still makes the fetch stale.
  assign IF_Ack   = if_ack_r && !IF_Flush;
  assign DM_Ack   = dm_ack_r;
  assign IF_RData = rdata;
  assign DM_RData = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected acks,
// a monitor tracks the bus and compares every acknowledge against the queue.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_Req, IF_Flush, IF_Ack;
  logic [31:0] IF_Address, IF_RData;
  logic        DM_Req, DM_R_W, DM_Ack;
  logic [2:0]  DM_Size;
  logic [31:0] DM_Address, DM_WData, DM_RData;
  logic        MEM_V, MEM_Cst_R_W, MEM_Ready_i, ERR;
  logic [2:0]  MEM_Cst_Size;
  logic [31:0] MEM_Address_o, MEM_RES_o, MEM_Data_Out_i;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_Req(IF_Req), .IF_Address(IF_Address), .IF_Flush(IF_Flush),
    .IF_Ack(IF_Ack), .IF_RData(IF_RData),
    .DM_Req(DM_Req), .DM_R_W(DM_R_W), .DM_Size(DM_Size),
    .DM_Address(DM_Address), .DM_WData(DM_WData),
    .DM_Ack(DM_Ack), .DM_RData(DM_RData),
    .MEM_V(MEM_V), .MEM_Cst_R_W(MEM_Cst_R_W), .MEM_Cst_Size(MEM_Cst_Size),
    .MEM_Address_o(MEM_Address_o), .MEM_RES_o(MEM_RES_o),
    .MEM_Data_Out_i(MEM_Data_Out_i), .MEM_Ready_i(MEM_Ready_i), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    int          ack_cyc;
    int          vlen;
    logic [31:0] addr;
    logic [2:0]  size;
    bit          rw;
    logic [31:0] wdata;
    int          gap;
    bit          err;
  } exp_t;

  exp_t sb[$];

  // Memory model: ready after mem_wait wait cycles, data = seed ^ address.
  int          mem_wait = 0;
  int          waited   = 0;
  logic [31:0] mem_seed = 32'h0;

  always @(negedge CLK) begin
    if (MEM_V) begin
      MEM_Data_Out_i = mem_seed ^ MEM_Address_o;
      if (waited == mem_wait) MEM_Ready_i = 1'b1;
      else begin
        MEM_Ready_i = 1'b0;
        waited++;
      end
    end else begin
      MEM_Ready_i    = 1'b0;
      MEM_Data_Out_i = 32'h0;
      waited         = 0;
    end
  end

  // Monitor: bus-phase bookkeeping plus scoreboard comparison on every Ack.
  bit          prev_v = 1'b0;
  int          gap_cnt = 100;
  int          cur_vlen, cur_gap;
  bit          cur_stable, cur_rw;
  logic [2:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;

  always @(negedge CLK) begin
    if (MEM_V) begin
      if (!prev_v) begin
        cur_vlen   = 1;
        cur_gap    = gap_cnt;
        cur_stable = 1'b1;
        cur_rw     = MEM_Cst_R_W;
        cur_size   = MEM_Cst_Size;
        cur_addr   = MEM_Address_o;
        cur_wdata  = MEM_RES_o;
      end else begin
        cur_vlen++;
        if (MEM_Cst_R_W !== cur_rw || MEM_Cst_Size !== cur_size ||
            MEM_Address_o !== cur_addr || MEM_RES_o !== cur_wdata)
          cur_stable = 1'b0;
      end
      gap_cnt = 0;
    end else begin
      gap_cnt++;
    end
    prev_v = MEM_V;

    if (IF_Ack === 1'b1 || DM_Ack === 1'b1) begin
      chk("ack_exclusive", {31'd0, IF_Ack & DM_Ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, DM_Ack, IF_Ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_owner_dm", {31'd0, DM_Ack}, {31'd0, e.dm});
        chk("rdata", e.dm ? DM_RData : IF_RData, e.rdata);
        chk("ack_cycle", cyc, e.ack_cyc);
        chk("mem_v_len", cur_vlen, e.vlen);
        chk("mem_addr", cur_addr, e.addr);
        chk("mem_size", {29'd0, cur_size}, {29'd0, e.size});
        chk("mem_rw", {31'd0, cur_rw}, {31'd0, e.rw});
        if (e.rw) chk("mem_wdata", cur_wdata, e.wdata);
        chk("bus_stable", {31'd0, cur_stable}, 32'd1);
        chk("err_flag", {31'd0, ERR}, {31'd0, e.err});
        if (e.gap >= 0) chk("idle_gap", cur_gap, e.gap);
      end
    end
  end

  task automatic push(input bit dm, input logic [31:0] rdata, input int ack_cyc,
                      input int vlen, input logic [31:0] addr, input logic [2:0] size,
                      input bit rw, input logic [31:0] wdata, input int gap, input bit err);
    exp_t e;
    e.dm = dm; e.rdata = rdata; e.ack_cyc = ack_cyc; e.vlen = vlen; e.addr = addr;
    e.size = size; e.rw = rw; e.wdata = wdata; e.gap = gap; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit dm);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (dm ? DM_Ack : IF_Ack) got = 1'b1;
    end
    if (dm) DM_Req = 1'b0;
    else    IF_Req = 1'b0;
    chk(dm ? "dm_ack_arrived" : "if_ack_arrived", {31'd0, got}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic dm_drive(input bit rw, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    DM_Req = 1'b1; DM_R_W = rw; DM_Size = size; DM_Address = addr; DM_WData = wdata;
  endtask

  int c;

  initial begin
    RESET = 1'b1;
    IF_Req = 1'b0; IF_Address = 32'h0; IF_Flush = 1'b0;
    DM_Req = 1'b0; DM_R_W = 1'b0; DM_Size = 3'b0; DM_Address = 32'h0; DM_WData = 32'h0;
    MEM_Ready_i = 1'b0; MEM_Data_Out_i = 32'h0;
    idle(3);
    chk("rst_mem_v", {31'd0, MEM_V}, 32'd0);
    chk("rst_acks", {30'd0, IF_Ack, DM_Ack}, 32'd0);
    chk("rst_addr", MEM_Address_o, 32'd0);
    chk("rst_rdata", DM_RData | IF_RData, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    RESET = 1'b0;
    idle(2);

    // Single fetch, 3 wait cycles.
    mem_wait = 3; mem_seed = 32'h0051_3193;
    c = cyc;
    IF_Req = 1'b1; IF_Address = 32'h0000_0100;
    push(0, 32'h0051_3093, c + 5, 4, 32'h100, 3'b010, 0, 32'h0, -1, 0);
    wait_ack(0);
    idle(3);

    // Collision: DM wins, IF follows after two idle cycles.
    mem_wait = 0; mem_seed = 32'hA5A5_0000;
    c = cyc;
    dm_drive(0, 3'b000, 32'h0000_2000, 32'h0);
    IF_Req = 1'b1; IF_Address = 32'h0000_0300;
    push(1, 32'hA5A5_2000, c + 2, 1, 32'h2000, 3'b000, 0, 32'h0, -1, 0);
    push(0, 32'hA5A5_0300, c + 5, 1, 32'h300, 3'b010, 0, 32'h0, 2, 0);
    wait_ack(1);
    wait_ack(0);
    idle(3);

    // Store, 2 wait cycles.
    mem_wait = 2; mem_seed = 32'h1111_0000;
    c = cyc;
    dm_drive(1, 3'b010, 32'h0000_3004, 32'hDEAD_BEEF);
    push(1, 32'h1111_3004, c + 4, 3, 32'h3004, 3'b010, 1, 32'hDEAD_BEEF, -1, 0);
    wait_ack(1);
    idle(3);

    // Flush in the second BUSY_IF cycle; redirected fetch to 0x200 acked normally.
    mem_wait = 3; mem_seed = 32'h2222_0000;
    c = cyc;
    IF_Req = 1'b1; IF_Address = 32'h0000_0100;
    push(0, 32'h2222_0200, c + 11, 4, 32'h200, 3'b010, 0, 32'h0, 2, 0);
    while (cyc < c + 2) @(negedge CLK);
    IF_Flush = 1'b1; IF_Address = 32'h0000_0200;
    @(negedge CLK);
    IF_Flush = 1'b0;
    wait_ack(0);
    idle(3);

    // Timeout: ready never comes, TIMEOUT = 4.
    mem_wait = 1000; mem_seed = 32'h3333_0000;
    c = cyc;
    dm_drive(0, 3'b010, 32'h0000_4000, 32'h0);
    push(1, 32'h0, c + 5, 4, 32'h4000, 3'b010, 0, 32'h0, -1, 1);
    wait_ack(1);
    idle(3);
    chk("err_sticky_idle", {31'd0, ERR}, 32'd1);

    // Following load still works and ERR stays set.
    mem_wait = 1; mem_seed = 32'h4444_0000;
    c = cyc;
    dm_drive(0, 3'b001, 32'h0000_5002, 32'h0);
    push(1, 32'h4444_5002, c + 3, 2, 32'h5002, 3'b001, 0, 32'h0, -1, 1);
    wait_ack(1);
    idle(3);

    // Reset in BUSY_DM abandons the transaction.
    mem_wait = 1000;
    c = cyc;
    dm_drive(1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D);
    while (cyc < c + 2) @(negedge CLK);
    chk("busy_before_reset", {31'd0, MEM_V}, 32'd1);
    RESET = 1'b1; DM_Req = 1'b0;
    @(negedge CLK);
    chk("rst_mid_mem_v", {31'd0, MEM_V}, 32'd0);
    chk("rst_mid_rw_size", {28'd0, MEM_Cst_R_W, MEM_Cst_Size}, 32'd0);
    chk("rst_mid_addr", MEM_Address_o, 32'd0);
    chk("rst_mid_wdata", MEM_RES_o, 32'd0);
    chk("rst_mid_acks", {30'd0, IF_Ack, DM_Ack}, 32'd0);
    chk("rst_mid_rdata", IF_RData | DM_RData, 32'd0);
    chk("rst_mid_err", {31'd0, ERR}, 32'd0);
    RESET = 1'b0;
    idle(4);

    // Fresh fetch after reset at nominal latency.
    mem_wait = 0; mem_seed = 32'h5555_0000;
    c = cyc;
    IF_Req = 1'b1; IF_Address = 32'h0000_0400;
    push(0, 32'h5555_0400, c + 2, 1, 32'h400, 3'b010, 0, 32'h0, -1, 0);
    wait_ack(0);
    idle(5);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_time_limit actual=%0d required=finish", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port of the core between the fetch stage (instruction reads) and the memory stage (data loads/stores). It runs one transaction at a time, with data requests taking priority. It holds a request on the external port until memory signals completion, then returns the data to the winning requester with a one-cycle acknowledge. In-flight fetches that a branch redirect makes stale are discarded, and a hung memory is bounded by a timeout.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles `MEM_V` may stay high without `MEM_Ready_i` before the transaction is aborted. Legal range 1–65535.
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `IF_Req` in 1: fetch request. Held high, with a stable address, until `IF_Ack`.
- `IF_Address` in 32: fetch address. A word read, size 3'b010.
- `IF_Flush` in 1: redirect pulse from the fetch stage (branch/jump taken).
- `IF_Ack` out 1: one-cycle completion for fetch.
- `IF_RData` out 32: instruction word. Valid while `IF_Ack` is high.
- `DM_Req` in 1: data request. Held high, with stable qualifiers, until `DM_Ack`.
- `DM_R_W` in 1: 1 = store, 0 = load.
- `DM_Size` in 3: access size, 3'b000 = byte, 3'b001 = half, 3'b010 = word.
- `DM_Address` in 32: data address.
- `DM_WData` in 32: store data.
- `DM_Ack` out 1: one-cycle completion for data.
- `DM_RData` out 32: load data. Valid while `DM_Ack` is high.
- `MEM_V` out 1: external request valid.
- `MEM_Cst_R_W` out 1: external read/write, same encoding as `DM_R_W`.
- `MEM_Cst_Size` out 3: external size.
- `MEM_Address_o` out 32: external address.
- `MEM_RES_o` out 32: external write data.
- `MEM_Data_Out_i` in 32: external read data. Valid when `MEM_Ready_i` is high.
- `MEM_Ready_i` in 1: external completion. Sampled only while `MEM_V` is high.
- `ERR` out 1: sticky timeout flag. Cleared only by `RESET`.

## Operation
- States: `IDLE`, `BUSY_DM`, `BUSY_IF`, `RESP`. Owner register `own` takes values DM or IF. Drop flag `drop`.
- **IDLE**
  - If `DM_Req` is high: latch the DM qualifiers into the external output registers, set `own` = DM, go to `BUSY_DM`.
  - Else if `IF_Req` is high and `IF_Flush` is low: latch `IF_Address`, drive R_W = 0 and Size = 3'b010, set `own` = IF, clear `drop`, go to `BUSY_IF`.
  - Otherwise stay in IDLE.
  - DM always wins a simultaneous request.
- **BUSY_x**
  - `MEM_V` = 1. All `MEM_*` outputs are registered and stable.
  - When `MEM_Ready_i` is high: capture `MEM_Data_Out_i` into the shared read-data register, go to `RESP`.
  - Timeout counter (16-bit) resets on entry and increments each cycle without ready.
  - When the counter equals `TIMEOUT - 1` and ready is still low: set `ERR`, load read data = 0, go to `RESP`.
- **BUSY_IF**: `IF_Flush` high in any cycle sets `drop`. The bus transaction still completes; it is never withdrawn.
- **RESP**
  - `MEM_V` = 0.
  - If `own` = DM: `DM_Ack` = 1.
  - If `own` = IF: `IF_Ack` = `!drop & !IF_Flush`.
  - Always go to `IDLE` next cycle.
  - Requests are not sampled in RESP. This guarantees that a requester deasserting its Req on the edge after Ack is never double-issued.
- `IF_RData` and `DM_RData` both drive from the shared read-data register. Each is meaningful only alongside its Ack.
- Stores return `DM_Ack` with `DM_RData` = the value captured from the bus. Content is don't-care.
- **Reset**
  - Any state goes to IDLE.
  - All outputs go to 0: `MEM_V`, `MEM_Cst_R_W`, `MEM_Cst_Size`, `MEM_Address_o`, `MEM_RES_o`, both Acks, both RData outputs, and `ERR`.
  - `drop` = 0, counter = 0.
  - Reset in the middle of a transaction abandons it. No Ack is issued.

## Timing
- Minimum latency, request sampled in cycle 0:
  - `MEM_V` high in cycle 1.
  - `MEM_Ready_i` earliest in cycle 1.
  - Ack in cycle 2.
  - IDLE in cycle 3.
  - This gives a 3-cycle turnaround, and 2 + (ready wait) cycles in general.
- Back-to-back: a request still high in cycle 3 is arbitrated in cycle 3. `MEM_V` is therefore low for at least 2 cycles between transactions.
- Timeout: `MEM_V` is high for exactly `TIMEOUT` cycles. Ack follows the next cycle, with `ERR` high from that same cycle.
- Flush in the same cycle as the `BUSY_IF` ready edge: the data is still captured and `IF_Ack` is suppressed.
- Flush in `IDLE` with `IF_Req` high: no grant that cycle. The IF request is re-evaluated the next cycle, with the new address.

## Test plan
- Single fetch: `IF_Req` with 0x0000_0100, memory ready after 3 wait cycles with 0x0051_3093 -> `MEM_V` high for cycles 1–4, Size 3'b010, R_W 0; `IF_Ack` with `IF_RData` = 0x0051_3093 in cycle 5.
- Collision: `IF_Req` and `DM_Req` (load, byte, 0x2000) raised in the same cycle, ready is immediate -> DM is served first with `MEM_Address_o` = 0x2000 and `MEM_Cst_Size` = 3'b000; the IF request is issued in the cycle after `DM_Ack` + 1.
- Store: `DM_R_W` = 1, `DM_WData` = 0xDEAD_BEEF, address 0x3004 -> `MEM_Cst_R_W` = 1 and `MEM_RES_o` = 0xDEAD_BEEF held stable until ready; one `DM_Ack`.
- Flush mid-fetch: `IF_Flush` pulse in the second `BUSY_IF` cycle -> the transaction completes on the bus, no `IF_Ack`; the next fetch to 0x0000_0200 is acked normally.
- Timeout: `TIMEOUT` = 4, ready never asserts -> `MEM_V` high for exactly 4 cycles; `DM_Ack` with `DM_RData` = 0; `ERR` = 1 and stays set through subsequent transactions.
- Reset mid-transaction: `RESET` in `BUSY_DM` -> all outputs are 0 the next cycle, no Ack; a fresh request after reset follows nominal latency.
